// File: rtl/fxp_pkg.sv
// Shared widths, Q formats and types for the fixed-point arithmetic unit.
package fxp_pkg;

  localparam int W_IN        = 17;
  localparam int OP1_FRAC    = 14;
  localparam int OP2_FRAC    = 12;
  localparam int ALIGN_SHIFT = OP1_FRAC - OP2_FRAC;
  localparam int W_SUM       = 18;
  localparam int W_PROD      = 35;
  localparam int PROD_FRAC   = OP1_FRAC + OP2_FRAC;
  localparam int W_PROD_RAW  = 2 * W_IN;

  typedef logic signed [W_IN-1:0]       op_t;
  typedef logic signed [W_SUM-1:0]      sum_t;
  typedef logic signed [W_PROD-1:0]     prod_t;
  typedef logic signed [W_PROD_RAW-1:0] prod_raw_t;

endpackage

// File: rtl/fxp_align.sv
// Aligns a Q2.14 operand to Q2.12 by a flooring arithmetic shift, sign-extended to W_SUM.
module fxp_align
  import fxp_pkg::*;
(
  input  logic signed [W_IN-1:0]  a,
  output logic signed [W_SUM-1:0] y
);

  sum_t a_ext;

  // Extending first keeps the shift exact and equal to extending the shifted value.
  assign a_ext = sum_t'(a);
  assign y     = a_ext >>> ALIGN_SHIFT;

endmodule

// File: rtl/fixed_point_arthematic.sv
// Registered aligned sum, aligned difference and full-precision product of two
// signed fixed-point operands; one-cycle latency, async active-high reset.
module fixed_point_arthematic
  import fxp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [W_IN-1:0]   operand_1,
  input  logic signed [W_IN-1:0]   operand_2,
  output logic signed [W_SUM-1:0]  sum,
  output logic signed [W_SUM-1:0]  diff,
  output logic signed [W_PROD-1:0] product
);

  sum_t      a1;
  sum_t      b_ext;
  sum_t      sum_nxt;
  sum_t      diff_nxt;
  prod_raw_t prod_raw;
  prod_t     prod_nxt;

  fxp_align u_align (
    .a (operand_1),
    .y (a1)
  );

  assign b_ext    = sum_t'(operand_2);
  assign sum_nxt  = a1 + b_ext;
  assign diff_nxt = a1 - b_ext;

  // Unshifted operand_1 keeps all 26 fraction bits in the product.
  assign prod_raw = prod_raw_t'(operand_1) * prod_raw_t'(operand_2);
  assign prod_nxt = prod_t'(prod_raw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      diff    <= '0;
      product <= '0;
    end else begin
      sum     <= sum_nxt;
      diff    <= diff_nxt;
      product <= prod_nxt;
    end
  end

endmodule

// File: tb/tb_fixed_point_arthematic.sv
// Scoreboard bench for fixed_point_arthematic: directed vectors, random stream, reset pulses.
module tb_fixed_point_arthematic;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [16:0] operand_1 = '0;
  logic signed [16:0] operand_2 = '0;
  logic signed [17:0] sum;
  logic signed [17:0] diff;
  logic signed [34:0] product;

  typedef struct {
    int     s;
    int     d;
    longint p;
    int     id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fixed_point_arthematic dut (
    .clk       (clk),
    .rst       (rst),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .sum       (sum),
    .diff      (diff),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int id);
    exp_t e;
    int   a1;
    a1   = a >>> 2;
    e.s  = a1 + b;
    e.d  = a1 - b;
    e.p  = longint'(a) * longint'(b);
    e.id = id;
    return e;
  endfunction

  task automatic drive_now(input int a, input int b, input int es, input int ed,
                           input longint ep, input int id);
    exp_t e;
    operand_1 = 17'(a);
    operand_2 = 17'(b);
    e.s = es; e.d = ed; e.p = ep; e.id = id;
    q.push_back(e);
  endtask

  task automatic drive(input int a, input int b, input int es, input int ed,
                       input longint ep, input int id);
    @(negedge clk);
    drive_now(a, b, es, ed, ep, id);
  endtask

  task automatic drive_rand(input int id);
    int   a;
    int   b;
    exp_t e;
    a = int'($urandom_range(131071)) - 65536;
    b = int'($urandom_range(131071)) - 65536;
    e = model(a, b, id);
    drive(a, b, e.s, e.d, e.p, id);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sum"},  sum,     0);
    chk({tag, "_diff"}, diff,    0);
    chk({tag, "_prod"}, product, 0);
  endtask

  // Monitor: every edge the DUT presents a new result; pop and compare if one is owed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("v%0d_sum", e.id),  sum,     e.s);
        chk($sformatf("v%0d_diff", e.id), diff,    e.d);
        chk($sformatf("v%0d_prod", e.id), product, e.p);
      end
    end
  end

  initial begin
    #2;
    operand_1 = 17'sd1234;
    operand_2 = -17'sd77;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("rst_held");

    @(negedge clk);
    rst = 1'b0;
    drive_now(1234, -77, 231, 385, -64'sd95018, 0);

    drive( 16384,   4096,   8192,      0,  64'sd67108864,    1);
    drive(     3,      0,      0,      0,  64'sd0,           2);
    drive(    -1,      0,     -1,     -1,  64'sd0,           3);
    drive(-65536,  65535,  49151, -81919, -64'sd4294901760,  4);
    drive(-65536, -65536, -81920,  49152,  64'sd4294967296,  5);

    for (int i = 0; i < 120; i++) drive_rand(100 + i);

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    #1;
    rst = 1'b0;

    for (int i = 120; i < 241; i++) drive_rand(100 + i);

    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
